maze_solver_ctrl: RTL and testbench
===================================

Name: maze_solver_ctrl

Overview:
- Depth-first "rat in maze" search controller that sequences the 16x16 one-bit maze memory.
- Drives the memory's address, read, write and data-in lines. Reads cells to find open neighbours and writes 1 into each visited cell to mark it.
- Keeps a LIFO of move directions, so the stack contents at completion are the start-to-goal path.
- Sits between the top-level start/status logic and the maze memory. It is the only master of that memory during a search.

Parameters:
- SIZE, 16, maze edge length in cells. Start cell is (0,0); goal cell is (SIZE-1,SIZE-1).
- AW, 4, address width per axis (clog2 SIZE).
- DEPTH, 64, direction-stack entries. This is the maximum path length.
- SPW, 7, stack-pointer width; must hold 0..DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a search; ignored while busy.
- adrX  out  AW  memory column address.
- adrY  out  AW  memory row address.
- mem_rd  out  1  one-cycle read strobe.
- mem_dout  in  1  memory read data, valid the cycle after mem_rd.
- mem_wr  out  1  one-cycle write strobe.
- mem_din  out  1  memory write data; always 1 when mem_wr is high.
- busy  out  1  search in progress.
- done  out  1  goal reached; held until the next accepted start.
- fail  out  1  no path exists; held until the next accepted start.
- path_len  out  SPW  number of moves on the found path (equals stack pointer).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0; cur=(0,0); dir=0; sp=0.
  - Reset mid-search aborts immediately. Memory contents already marked stay marked.
- Cell encoding: 0 = open, 1 = wall or visited.
- Directions, tried in this order per cell: 0=Right(X+1), 1=Down(Y+1), 2=Left(X-1), 3=Up(Y-1).
- IDLE:
  - On start: clear done and fail, set busy, cur=(0,0), sp=0, dir=0, go to CHK0.
- CHK0: mem_rd=1 with address=cur. Go to CHK0W.
- CHK0W: sample mem_dout.
  - 1 → FAIL.
  - 0 → MARK.
- MARK: mem_wr=1, mem_din=1, address=cur.
  - If cur is the goal → DONE.
  - Otherwise → PROBE.
- PROBE:
  - dir==4 → BACK.
  - Otherwise compute the neighbour. If it is off-grid (X or Y would leave 0..SIZE-1), or sp==DEPTH: dir++, stay in PROBE. No memory access is made.
  - Otherwise mem_rd=1 with address=neighbour, go to EVAL.
- EVAL: sample mem_dout.
  - 1: dir++, go to PROBE.
  - 0: push dir, sp++, cur=neighbour, dir=0, go to MARK.
- BACK:
  - sp==0 → FAIL.
  - Otherwise pop d, sp--, cur = cur minus step(d), dir=d+1, go to PROBE.
- DONE: busy=0, done=1, path_len=sp, go to IDLE (or to DUMP when the optional feature is enabled).
- FAIL: busy=0, fail=1, path_len=0, go to IDLE.
- Strobe rules:
  - mem_rd and mem_wr are never high in the same cycle.
  - Each strobe lasts exactly one cycle.
  - adrX/adrY are stable during the strobe cycle and hold their last value otherwise.
- Arithmetic: neighbour computation uses AW+1 bits so that underflow and overflow are detected; no wrap-around is allowed.
- start while busy: ignored, no effect.
- Latency:
  - One read per probe: 2 cycles.
  - One move: 3 cycles (MARK plus read/eval).
  - Blocked direction: 1 cycle if off-grid or stack full, 2 cycles if it reads a wall.

Optional Feature:
- Macro: MAZE_PATH_DUMP_EN.
- When defined:
  - Add outputs path_dir (2 bits) and path_vld (1 bit).
  - After DONE the controller enters DUMP and streams stack entries bottom-to-top, one per cycle, with path_vld=1. This takes path_len cycles.
  - done asserts on the cycle after the last entry.
  - busy stays high during DUMP.
  - A path_len of 0 produces no beats.
- When not defined: no extra ports; DONE asserts directly as described above.

Test Plan:
- All-zero maze, start → mem_dout never 1.
  - Path goes Right to (15,0), then Down to (15,15).
  - done=1, path_len=30, fail=0.
  - 31 mem_wr pulses, each with mem_din=1.
- Cell (0,0)=1, start → fail=1 within 4 cycles, zero mem_wr pulses, path_len=0.
- Walls at (14,15) and (15,14), all else 0, start → fail=1.
  - Every other cell reachable from (0,0) is written 1 exactly once.
  - mem_rd is never issued with an off-grid address.
- Dead-end: row 0 open only up to x=3, (3,1)=1, column 0 open downward, start.
  - Controller backtracks from (3,0) to (0,0), then goes Down.
  - done=1 with a correct path_len.
  - Stack pointer returns to 0 during the backtrack.
- DEPTH=8, all-zero maze → fail=1, since no path of 8 or fewer moves exists. sp never exceeds 8.
- Reset mid-search: pull rst low for 1 cycle while busy in the all-zero maze.
  - All outputs are 0 immediately.
  - A later start restarts from (0,0). Already-marked cells block it, so the second search on the unreset memory ends with fail=1.

Source files
------------

// File: rtl/maze_solver_ctrl.sv
// Depth-first maze search master for a SIZE x SIZE one-bit maze memory.
// Define MAZE_PATH_DUMP_EN to stream the found path on path_dir/path_vld.
module maze_solver_ctrl #(
  parameter int SIZE  = 16,
  parameter int AW    = 4,
  parameter int DEPTH = 64,
  parameter int SPW   = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [AW-1:0]  adrX,
  output logic [AW-1:0]  adrY,
  output logic           mem_rd,
  input  logic           mem_dout,
  output logic           mem_wr,
  output logic           mem_din,
  output logic           busy,
  output logic           done,
  output logic           fail,
  output logic [SPW-1:0] path_len
`ifdef MAZE_PATH_DUMP_EN
  ,
  output logic [1:0]     path_dir,
  output logic           path_vld
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [AW:0]    LIM   = (AW+1)'(SIZE - 1);
  localparam logic [AW-1:0]  GOAL  = AW'(SIZE - 1);
  localparam logic [AW:0]    ONE_N = (AW+1)'(1);
  localparam logic [AW-1:0]  ONE_A = AW'(1);
  localparam logic [SPW-1:0] ONE_S = SPW'(1);
  localparam logic [SPW-1:0] FULL  = SPW'(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_CHK0, S_CHK0W, S_MARK, S_PROBE,
    S_EVAL, S_BACK, S_DONE, S_FAIL, S_DUMP
  } state_e;

  state_e state_q, state_d;
  logic [AW-1:0]  cx_q, cx_d, cy_q, cy_d;
  logic [2:0]     dir_q, dir_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [SPW-1:0] len_q, len_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           fail_q, fail_d;
  logic [AW-1:0]  ax_q, ay_q, ax, ay;
  logic           push;
  logic [1:0]     stk_q [DEPTH];
`ifdef MAZE_PATH_DUMP_EN
  logic [SPW-1:0] idx_q, idx_d;
`endif

  logic [AW:0]   nx, ny;
  logic          off, blocked, at_goal;
  logic [1:0]    top_dir;
  logic [AW-1:0] bx, by;

  assign top_dir = stk_q[IW'(sp_q - ONE_S)];
  assign at_goal = (cx_q == GOAL) && (cy_q == GOAL);
  assign off     = (nx > LIM) || (ny > LIM);
  assign blocked = off || (sp_q == FULL);

  // Extra bit catches both underflow and overflow off the grid
  always_comb begin
    nx = {1'b0, cx_q};
    ny = {1'b0, cy_q};
    unique case (dir_q[1:0])
      2'd0: nx = {1'b0, cx_q} + ONE_N;
      2'd1: ny = {1'b0, cy_q} + ONE_N;
      2'd2: nx = {1'b0, cx_q} - ONE_N;
      2'd3: ny = {1'b0, cy_q} - ONE_N;
      default: ;
    endcase
  end

  always_comb begin
    bx = cx_q;
    by = cy_q;
    unique case (top_dir)
      2'd0: bx = cx_q - ONE_A;
      2'd1: by = cy_q - ONE_A;
      2'd2: bx = cx_q + ONE_A;
      2'd3: by = cy_q + ONE_A;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      dir_q   <= '0;
      sp_q    <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      ax_q    <= '0;
      ay_q    <= '0;
`ifdef MAZE_PATH_DUMP_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dir_q   <= dir_d;
      sp_q    <= sp_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      ax_q    <= ax;
      ay_q    <= ay;
`ifdef MAZE_PATH_DUMP_EN
      idx_q   <= idx_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) stk_q[IW'(sp_q)] <= dir_q[1:0];
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dir_d   = dir_q;
    sp_d    = sp_q;
    len_d   = len_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fail_d  = fail_q;
    push    = 1'b0;
`ifdef MAZE_PATH_DUMP_EN
    idx_d   = idx_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          fail_d  = 1'b0;
          busy_d  = 1'b1;
          cx_d    = '0;
          cy_d    = '0;
          sp_d    = '0;
          dir_d   = '0;
          state_d = S_CHK0;
        end
      end
      S_CHK0:  state_d = S_CHK0W;
      S_CHK0W: state_d = mem_dout ? S_FAIL : S_MARK;
      S_MARK:  state_d = at_goal ? S_DONE : S_PROBE;
      S_PROBE: begin
        if (dir_q[2]) state_d = S_BACK;
        else if (blocked) dir_d = dir_q + 3'd1;
        else state_d = S_EVAL;
      end
      S_EVAL: begin
        if (mem_dout) begin
          dir_d   = dir_q + 3'd1;
          state_d = S_PROBE;
        end else begin
          push    = 1'b1;
          sp_d    = sp_q + ONE_S;
          cx_d    = nx[AW-1:0];
          cy_d    = ny[AW-1:0];
          dir_d   = '0;
          state_d = S_MARK;
        end
      end
      S_BACK: begin
        if (sp_q == '0) begin
          state_d = S_FAIL;
        end else begin
          sp_d    = sp_q - ONE_S;
          cx_d    = bx;
          cy_d    = by;
          dir_d   = {1'b0, top_dir} + 3'd1;
          state_d = S_PROBE;
        end
      end
      S_DONE: begin
        len_d = sp_q;
`ifdef MAZE_PATH_DUMP_EN
        if (sp_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          idx_d   = '0;
          state_d = S_DUMP;
        end
`else
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
`endif
      end
      S_FAIL: begin
        busy_d  = 1'b0;
        fail_d  = 1'b1;
        len_d   = '0;
        state_d = S_IDLE;
      end
`ifdef MAZE_PATH_DUMP_EN
      S_DUMP: begin
        idx_d = idx_q + ONE_S;
        if (idx_q == sp_q - ONE_S) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Address only moves on a strobe cycle; otherwise it holds
  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    mem_din = 1'b0;
    ax      = ax_q;
    ay      = ay_q;
`ifdef MAZE_PATH_DUMP_EN
    path_vld = 1'b0;
    path_dir = 2'd0;
`endif
    unique case (state_q)
      S_CHK0: begin
        mem_rd = 1'b1;
        ax     = cx_q;
        ay     = cy_q;
      end
      S_MARK: begin
        mem_wr  = 1'b1;
        mem_din = 1'b1;
        ax      = cx_q;
        ay      = cy_q;
      end
      S_PROBE: begin
        if (!dir_q[2] && !blocked) begin
          mem_rd = 1'b1;
          ax     = nx[AW-1:0];
          ay     = ny[AW-1:0];
        end
      end
`ifdef MAZE_PATH_DUMP_EN
      S_DUMP: begin
        path_vld = 1'b1;
        path_dir = stk_q[IW'(idx_q)];
      end
`endif
      default: ;
    endcase
  end

  assign adrX     = ax;
  assign adrY     = ay;
  assign busy     = busy_q;
  assign done     = done_q;
  assign fail     = fail_q;
  assign path_len = len_q;

endmodule

// File: tb/tb_maze_solver_ctrl.sv
// Bench for maze_solver_ctrl: fixed and random mazes against a DFS model.
// Two instances: default depth 64 and a shallow depth-8 stack.
module tb_maze_solver_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;

  logic [3:0] ax, ay, bx, by;
  logic rd_a, wr_a, din_a, busy_a, done_a, fail_a;
  logic rd_b, wr_b, din_b, busy_b, done_b, fail_b;
  logic dout_a = 1'b0, dout_b = 1'b0;
  logic [6:0] len_a;
  logic [3:0] len_b;

  logic [255:0] mem_a = '0, mem_b = '0;
  int wcnt_a = 0, wcnt_b = 0;
  int ovl = 0, bad_din = 0, dup = 0;
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  maze_solver_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .adrX(ax), .adrY(ay), .mem_rd(rd_a), .mem_dout(dout_a),
    .mem_wr(wr_a), .mem_din(din_a), .busy(busy_a),
    .done(done_a), .fail(fail_a), .path_len(len_a)
  );

  maze_solver_ctrl #(.DEPTH(8), .SPW(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .adrX(bx), .adrY(by), .mem_rd(rd_b), .mem_dout(dout_b),
    .mem_wr(wr_b), .mem_din(din_b), .busy(busy_b),
    .done(done_b), .fail(fail_b), .path_len(len_b)
  );

  always @(posedge clk) begin
    if (rd_a) dout_a <= mem_a[{ay, ax}];
    if (rd_a && wr_a) ovl++;
    if (wr_a) begin
      if (!din_a) bad_din++;
      if (mem_a[{ay, ax}]) dup++;
      mem_a[{ay, ax}] = 1'b1;
      wcnt_a++;
    end
  end

  always @(posedge clk) begin
    if (rd_b) dout_b <= mem_b[{by, bx}];
    if (rd_b && wr_b) ovl++;
    if (wr_b) begin
      if (!din_b) bad_din++;
      if (mem_b[{by, bx}]) dup++;
      mem_b[{by, bx}] = 1'b1;
      wcnt_b++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int dxf(input int d);
    if (d == 0) return 1;
    if (d == 2) return -1;
    return 0;
  endfunction

  function automatic int dyf(input int d);
    if (d == 1) return 1;
    if (d == 3) return -1;
    return 0;
  endfunction

  // DFS by the search rules; cycles tallied from the latency rules
  task automatic model(input logic [255:0] img, input int depth,
                       output bit m_done, output int m_len,
                       output int m_wr, output int m_cyc,
                       output logic [255:0] g);
    int x, y, nx, ny, d, p;
    bit fin;
    int stk[$];
    g = img;
    m_done = 0;
    m_len = 0;
    m_wr = 0;
    m_cyc = 2;
    x = 0;
    y = 0;
    d = 0;
    fin = g[0];
    if (fin) m_cyc += 1;
    else begin
      g[0] = 1'b1;
      m_wr = 1;
      m_cyc += 1;
    end
    while (!fin) begin
      if (d == 4) begin
        m_cyc += 2;
        if (stk.size() == 0) begin
          m_cyc += 1;
          fin = 1;
        end else begin
          p = stk.pop_back();
          x -= dxf(p);
          y -= dyf(p);
          d = p + 1;
        end
      end else begin
        m_cyc += 1;
        nx = x + dxf(d);
        ny = y + dyf(d);
        if (nx < 0 || nx > 15 || ny < 0 || ny > 15 || stk.size() >= depth)
          d++;
        else begin
          m_cyc += 1;
          if (g[ny*16+nx]) d++;
          else begin
            stk.push_back(d);
            x = nx;
            y = ny;
            d = 0;
            g[ny*16+nx] = 1'b1;
            m_wr++;
            m_cyc += 1;
            if (x == 15 && y == 15) begin
              m_cyc += 1;
              m_done = 1;
              m_len = stk.size();
              fin = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic go(input bit sel, input bit poke, output int n);
    @(negedge clk);
    if (sel) start_b = 1'b1;
    else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    n = 0;
    while (!(sel ? (done_b | fail_b) : (done_a | fail_a)) && n < 20000) begin
      if (poke && n == 5) begin
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
      end
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      n++;
    end
  endtask

  task automatic run_case(input string tag, input logic [255:0] img,
                          input bit sel, input bit poke,
                          output int r_len, output int r_wr);
    bit m_done;
    int m_len, m_wr, m_cyc, n, w0;
    logic [255:0] m_g;
    model(img, sel ? 8 : 64, m_done, m_len, m_wr, m_cyc, m_g);
    if (sel) begin
      mem_b = img;
      w0 = wcnt_b;
    end else begin
      mem_a = img;
      w0 = wcnt_a;
    end
    go(sel, poke, n);
    chk({tag, ".cyc"}, 32'(n), 32'(m_cyc));
    if (sel) begin
      chk({tag, ".done"}, 32'(done_b), 32'(m_done));
      chk({tag, ".fail"}, 32'(fail_b), 32'(!m_done));
      chk({tag, ".len"}, 32'(len_b), 32'(m_len));
      chk({tag, ".busy"}, 32'(busy_b), 32'(0));
      chk({tag, ".wr"}, 32'(wcnt_b - w0), 32'(m_wr));
      chk({tag, ".mem"}, 32'($countones(mem_b ^ m_g)), 32'(0));
      r_len = 32'(len_b);
      r_wr = wcnt_b - w0;
    end else begin
      chk({tag, ".done"}, 32'(done_a), 32'(m_done));
      chk({tag, ".fail"}, 32'(fail_a), 32'(!m_done));
      chk({tag, ".len"}, 32'(len_a), 32'(m_len));
      chk({tag, ".busy"}, 32'(busy_a), 32'(0));
      chk({tag, ".wr"}, 32'(wcnt_a - w0), 32'(m_wr));
      chk({tag, ".mem"}, 32'($countones(mem_a ^ m_g)), 32'(0));
      r_len = 32'(len_a);
      r_wr = wcnt_a - w0;
    end
  endtask

  initial begin
    logic [255:0] img;
    int l, w;
    #1;
    chk("rst.busy", 32'(busy_a), 32'(0));
    chk("rst.done", 32'(done_a), 32'(0));
    chk("rst.fail", 32'(fail_a), 32'(0));
    chk("rst.len", 32'(len_a), 32'(0));
    chk("rst.strb", 32'(rd_a | wr_a), 32'(0));
    chk("rst.adr", 32'({ay, ax}), 32'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    img = '0;
    run_case("zero", img, 1'b0, 1'b1, l, w);
    chk("zero.len30", 32'(l), 32'(30));
    chk("zero.wr31", 32'(w), 32'(31));

    img = '0;
    img[0] = 1'b1;
    run_case("blk0", img, 1'b0, 1'b0, l, w);
    chk("blk0.fail", 32'(fail_a), 32'(1));

    img = '0;
    img[15*16+14] = 1'b1;
    img[14*16+15] = 1'b1;
    run_case("moat", img, 1'b0, 1'b1, l, w);
    chk("moat.fail", 32'(fail_a), 32'(1));

    img = '1;
    for (int x = 0; x < 4; x++) img[x] = 1'b0;
    for (int y = 0; y < 16; y++) img[y*16] = 1'b0;
    for (int x = 0; x < 16; x++) img[15*16+x] = 1'b0;
    run_case("dead", img, 1'b0, 1'b0, l, w);
    chk("dead.len30", 32'(l), 32'(30));

    img = '0;
    run_case("d8zero", img, 1'b1, 1'b1, l, w);
    chk("d8zero.fail", 32'(fail_b), 32'(1));

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 256; i++) img[i] = ($urandom_range(0, 99) < 28);
      img[0] = 1'b0;
      img[255] = 1'b0;
      run_case("rnd", img, 1'b0, 1'b0, l, w);
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 256; i++) img[i] = ($urandom_range(0, 99) < 15);
      img[0] = 1'b0;
      run_case("rnd8", img, 1'b1, 1'b0, l, w);
    end

    mem_a = '0;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid.busy", 32'(busy_a), 32'(1));
    rst = 1'b0;
    #1;
    chk("arst.busy", 32'(busy_a), 32'(0));
    chk("arst.done", 32'(done_a | fail_a), 32'(0));
    chk("arst.len", 32'(len_a), 32'(0));
    chk("arst.strb", 32'(rd_a | wr_a), 32'(0));
    chk("arst.adr", 32'({ay, ax}), 32'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    chk("arst.mark", 32'(mem_a[0]), 32'(1));
    img = mem_a;
    run_case("rerun", img, 1'b0, 1'b0, l, w);
    chk("rerun.fail", 32'(fail_a), 32'(1));

    chk("ovl", 32'(ovl), 32'(0));
    chk("din", 32'(bad_din), 32'(0));
    chk("dup", 32'(dup), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
